sc_stream_engine: RTL and testbench
===================================

// Module: sc_stream_engine
// PURPOSE
//  Parametrised stream-cipher engine between UART RX and the TX print buffer. Commands 'E'/'D'/'L'
//  select encrypt, decrypt or key load; CR ends a command and pulses print_buf. Encrypt turns each
//  printable char into two ASCII-hex chars; decrypt turns hex pairs back into one char. Key/LFSR width
//  is a parameter; TX uses a valid/ready handshake and RX has a 1-deep holding register.
// PARAMETERS
//  LFSR_W      32            LFSR and key width in bits; multiple of 4, >= 8
//  KEY_NIBBLES LFSR_W/4      hex digits accepted in 'L' mode
//  TAPS        32'h8020_0003 feedback tap mask, LFSR_W bits
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset; synchronous, active-high
//  rx_valid   in   1        rx_data valid this cycle (one-cycle pulse)
//  rx_data    in   8        ASCII char from UART
//  tx_ready   in   1        sink accepts tx_data this cycle
//  tx_valid   out  1        tx_data valid; held until accepted
//  tx_data    out  8        ASCII char to the TX buffer
//  print_buf  out  1        one-cycle pulse: flush the TX buffer
//  mode       out  2        0 idle, 1 encrypt, 2 decrypt, 3 load (LED drive)
//  overrun    out  1        sticky: RX char dropped, holding register full
//  bad_char   out  1        sticky bad-char flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; key and LFSR = 1; holding register empty. rst mid-output drops the char.
//  RX hold: rx_valid writes the holding register. If it is full and not drained this cycle, the byte is dropped and overrun set.
//  The FSM consumes one held char per cycle, only in states ENC, DEC_HI, DEC_LO, LOAD, IDLE.
//  States: IDLE, ENC, ENC_HI, ENC_LO, DEC_HI, DEC_LO, DEC_OUT, LOAD.
//  CR (0x0D) in any consuming state: go to IDLE and pulse print_buf next cycle.
//   - DEC_LO: the latched high nibble is discarded.
//   - LOAD: a partial key is discarded.
//  IDLE: 'E'->ENC, 'D'->DEC_HI, 'L'->LOAD (nibble count cleared); anything else ignored.
//  ENC: char in 0x20..0x7E -> c = char ^ psr, step LFSR, go to ENC_HI; other chars ignored.
//  ENC_HI: tx_valid=1, tx_data = hex(c[7:4]) using uppercase '0'-'9','A'-'F'. On tx_ready go to ENC_LO.
//  ENC_LO: same with hex(c[3:0]); on tx_ready go to ENC.
//  Encrypt latency: char consumed in cycle N -> first tx_valid in cycle N+1.
//  DEC_HI: a hex char ('0'-'9','a'-'f','A'-'F') latches the high nibble, go to DEC_LO.
//  DEC_LO: a hex char gives p = {hi,lo} ^ psr; step LFSR; go to DEC_OUT. Non-hex chars ignored.
//  DEC_OUT: tx_data = p if p is 0x20..0x7E, else '.'; on tx_ready go to DEC_HI.
//  LOAD: each hex char shifts into a shadow key, MS nibble first. On nibble KEY_NIBBLES, key and LFSR
//   are both loaded from the shadow; extra hex chars are ignored until CR.
//  LFSR: Fibonacci, next = {lfsr[W-2:0], ^(lfsr & TAPS)}; psr = lfsr[7:0].
//   Loading all-zero loads 1 instead. The LFSR steps only on an encrypted or decrypted byte.
//  'E' and 'D' do not reseed: the stream continues. Reseed only by 'L'. Encrypting and decrypting from the same key round-trip.
// CONFIGURATION
//  SC_BADCHAR_FLAG_EN defined: a non-hex, non-CR char in DEC_HI, DEC_LO or LOAD sets bad_char (sticky, cleared by
//   rst or the next 'D'/'L') and emits '?' through the TX handshake before continuing.
//  Not defined: such chars are silently ignored and bad_char is tied 0.
// STRUCTURE
//  sc_pkg: state enum; ASCII constants (CR, 'E','D','L','.','?'); PRINT_LO=8'h20, PRINT_HI=8'h7E;
//   hex2bin/bin2hex/is_hex functions; default TAPS.
//  Sub-module sc_lfsr #(LFSR_W,TAPS): ports ld, ld_val, step, q; all-zero load guard inside.
// TESTING
//  1 "L00000001\r", "EA\r", tx_ready=1 -> tx "4","0" (0x41^0x01); print_buf pulses after each CR.
//  2 Reload "L00000001\r", then "D40\r" -> tx 'A'; the LFSR steps exactly once per pair; the round trip matches test 1.
//  3 tx_ready=0 for 20 cycles in ENC_HI -> tx_valid and tx_data stay stable; a 2nd rx char is held and a 3rd sets overrun.
//  4 "L12\r" (partial key) -> key and LFSR unchanged; the following encrypt matches the prior key.
//  5 "L00000000\r", "EA" -> the LFSR holds 1, so the output equals test 1.
//  6 With SC_BADCHAR_FLAG_EN, "DZ" -> tx '?' and bad_char=1; without it there is no tx and bad_char=0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared state encoding, ASCII constants and hex helpers for the stream-cipher engine.
package sc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ENC,
    ENC_HI,
    ENC_LO,
    DEC_HI,
    DEC_LO,
    DEC_OUT,
    LOAD,
    BAD
  } stateT;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_E     = 8'h45;
  localparam logic [7:0] CHAR_D     = 8'h44;
  localparam logic [7:0] CHAR_L     = 8'h4C;
  localparam logic [7:0] CHAR_DOT   = 8'h2E;
  localparam logic [7:0] CHAR_QUEST = 8'h3F;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_ENC  = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Letters of either case map to 10..15 because their low nibble is 1..6.
  function automatic logic [3:0] hex2bin(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return 4'(c[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] bin2hex(input logic [3:0] n);
    if (n < 4'd10) return 8'(8'h30 + {4'h0, n});
    return 8'(8'h37 + {4'h0, n});
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR with parallel load; an all-zero load is replaced by 1 so the register never locks up.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int unsigned       LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter int unsigned       Q_W    = LFSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [LFSR_W-1:0] ld_val,
  input  logic              step,
  output logic [Q_W-1:0]    q
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_W'(1);
    end else if (ld) begin
      lfsr <= (ld_val == '0) ? LFSR_W'(1) : ld_val;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end

  assign q = lfsr[Q_W-1:0];

endmodule

// File: rtl/sc_stream_engine.sv
// Stream-cipher engine between UART RX and the TX print buffer: 'E' hex-encrypts, 'D' decrypts, 'L' loads a key.
// Build option SC_BADCHAR_FLAG_EN: bad chars in decrypt/load raise sticky bad_char and echo '?'.
module sc_stream_engine
  import sc_pkg::*;
#(
  parameter int unsigned       LFSR_W      = 32,
  parameter int unsigned       KEY_NIBBLES = LFSR_W / 4,
  parameter logic [LFSR_W-1:0] TAPS        = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       print_buf,
  output logic [1:0] mode,
  output logic       overrun,
  output logic       bad_char
);

  localparam int unsigned CNT_W = $clog2(KEY_NIBBLES + 1);

  stateT             state;
  logic              holdValid;
  logic [7:0]        holdData;
  logic              canConsume;
  logic              consume;
  logic [7:0]        psr;
  logic [7:0]        encByte;
  logic [7:0]        decByte;
  logic [3:0]        encLo;
  logic [3:0]        hiNib;
  logic [LFSR_W-1:0] keyShadow;
  logic [LFSR_W-1:0] shadowNext;
  logic [CNT_W-1:0]  nibCnt;
  logic              lfsrLd;
  logic              lfsrStep;
`ifdef SC_BADCHAR_FLAG_EN
  stateT             retState;
`endif

  assign canConsume = (state == IDLE) || (state == ENC) || (state == DEC_HI) ||
                      (state == DEC_LO) || (state == LOAD);
  assign consume    = holdValid && canConsume;
  assign encByte    = holdData ^ psr;
  assign decByte    = {hiNib, hex2bin(holdData)} ^ psr;
  assign shadowNext = {keyShadow[LFSR_W-5:0], hex2bin(holdData)};

  // The loaded key only lives on as the LFSR seed, so the LFSR is the key state.
  sc_lfsr #(
    .LFSR_W(LFSR_W),
    .TAPS  (TAPS),
    .Q_W   (8)
  ) uLfsr (
    .clk   (clk),
    .rst   (rst),
    .ld    (lfsrLd),
    .ld_val(keyShadow),
    .step  (lfsrStep),
    .q     (psr)
  );

  // One-deep RX holding register; a byte arriving while it is full and not draining is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdValid <= 1'b0;
      holdData  <= '0;
      overrun   <= 1'b0;
    end else if (rx_valid) begin
      if (holdValid && !consume) begin
        overrun <= 1'b1;
      end else begin
        holdValid <= 1'b1;
        holdData  <= rx_data;
      end
    end else if (consume) begin
      holdValid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      print_buf <= 1'b0;
      mode      <= MODE_IDLE;
      encLo     <= '0;
      hiNib     <= '0;
      keyShadow <= '0;
      nibCnt    <= '0;
      lfsrLd    <= 1'b0;
      lfsrStep  <= 1'b0;
`ifdef SC_BADCHAR_FLAG_EN
      bad_char  <= 1'b0;
      retState  <= IDLE;
`endif
    end else begin
      print_buf <= 1'b0;
      lfsrLd    <= 1'b0;
      lfsrStep  <= 1'b0;
      // CR aborts any partial nibble or key and flushes the print buffer.
      if (consume && (holdData == CHAR_CR)) begin
        state     <= IDLE;
        mode      <= MODE_IDLE;
        print_buf <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (consume) begin
              if (holdData == CHAR_E) begin
                state <= ENC;
                mode  <= MODE_ENC;
              end else if (holdData == CHAR_D) begin
                state    <= DEC_HI;
                mode     <= MODE_DEC;
`ifdef SC_BADCHAR_FLAG_EN
                bad_char <= 1'b0;
`endif
              end else if (holdData == CHAR_L) begin
                state     <= LOAD;
                mode      <= MODE_LOAD;
                nibCnt    <= '0;
                keyShadow <= '0;
`ifdef SC_BADCHAR_FLAG_EN
                bad_char  <= 1'b0;
`endif
              end
            end
          end
          ENC: begin
            if (consume && is_printable(holdData)) begin
              encLo    <= encByte[3:0];
              tx_valid <= 1'b1;
              tx_data  <= bin2hex(encByte[7:4]);
              lfsrStep <= 1'b1;
              state    <= ENC_HI;
            end
          end
          ENC_HI: begin
            if (tx_ready) begin
              tx_data <= bin2hex(encLo);
              state   <= ENC_LO;
            end
          end
          ENC_LO: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= ENC;
            end
          end
          DEC_HI: begin
            if (consume) begin
              if (is_hex(holdData)) begin
                hiNib <= hex2bin(holdData);
                state <= DEC_LO;
              end
`ifdef SC_BADCHAR_FLAG_EN
              else begin
                bad_char <= 1'b1;
                tx_valid <= 1'b1;
                tx_data  <= CHAR_QUEST;
                retState <= DEC_HI;
                state    <= BAD;
              end
`endif
            end
          end
          DEC_LO: begin
            if (consume) begin
              if (is_hex(holdData)) begin
                tx_valid <= 1'b1;
                tx_data  <= is_printable(decByte) ? decByte : CHAR_DOT;
                lfsrStep <= 1'b1;
                state    <= DEC_OUT;
              end
`ifdef SC_BADCHAR_FLAG_EN
              else begin
                bad_char <= 1'b1;
                tx_valid <= 1'b1;
                tx_data  <= CHAR_QUEST;
                retState <= DEC_LO;
                state    <= BAD;
              end
`endif
            end
          end
          DEC_OUT: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= DEC_HI;
            end
          end
          LOAD: begin
            // The LFSR loads from the shadow one cycle after the final nibble lands.
            if (consume) begin
              if (is_hex(holdData)) begin
                if (nibCnt < CNT_W'(KEY_NIBBLES)) begin
                  keyShadow <= shadowNext;
                  nibCnt    <= nibCnt + CNT_W'(1);
                  if (nibCnt == CNT_W'(KEY_NIBBLES - 1)) lfsrLd <= 1'b1;
                end
              end
`ifdef SC_BADCHAR_FLAG_EN
              else begin
                bad_char <= 1'b1;
                tx_valid <= 1'b1;
                tx_data  <= CHAR_QUEST;
                retState <= LOAD;
                state    <= BAD;
              end
`endif
            end
          end
`ifdef SC_BADCHAR_FLAG_EN
          BAD: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= retState;
            end
          end
`endif
          default: begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            mode     <= MODE_IDLE;
          end
        endcase
      end
    end
  end

`ifndef SC_BADCHAR_FLAG_EN
  assign bad_char = 1'b0;
`endif

endmodule

// File: tb/tb_sc_stream_engine.sv
// Self-checking bench for sc_stream_engine: directed scenarios plus randomized round trips against a char-level model.
module tb_sc_stream_engine;

  localparam bit [31:0] TAPS_TB = 32'h8020_0003;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       print_buf;
  logic [1:0] mode;
  logic       overrun;
  logic       bad_char;

  int checks   = 0;
  int failures = 0;
  int printCnt = 0;
  bit randReady  = 0;
  bit forceReady = 1;

  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];

  // Reference model state (character-level behaviour of the engine)
  bit [31:0] mLfsr;
  int        mMode;
  bit        mHaveHi;
  int        mHi;
  int        mNib;
  bit [31:0] mShadow;
  bit        mBad;
  int        expPrints = 0;

  sc_stream_engine dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .print_buf(print_buf),
    .mode     (mode),
    .overrun  (overrun),
    .bad_char (bad_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = randReady ? 1'($urandom_range(0, 1)) : forceReady;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) gotQ.push_back(tx_data);
    if (!rst && print_buf) printCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit tbIsHex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic int tbHexVal(input logic [7:0] c);
    if (c <= "9") return int'(c) - 48;
    if (c >= "a") return int'(c) - 97 + 10;
    return int'(c) - 65 + 10;
  endfunction

  function automatic logic [7:0] tbHexChar(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  function automatic bit [31:0] tbStep(input bit [31:0] v);
    int fb;
    fb = $countones(v & TAPS_TB) % 2;
    return (v << 1) | 32'(fb);
  endfunction

  task automatic modelBad();
`ifdef SC_BADCHAR_FLAG_EN
    mBad = 1;
    expQ.push_back("?");
`endif
  endtask

  task automatic modelChar(input logic [7:0] c);
    int v;
    if (c == 8'h0D) begin
      mMode = 0;
      mHaveHi = 0;
      expPrints++;
      return;
    end
    case (mMode)
      0: begin
        if (c == "E") mMode = 1;
        else if (c == "D") begin mMode = 2; mHaveHi = 0; mBad = 0; end
        else if (c == "L") begin mMode = 3; mNib = 0; mShadow = 0; mBad = 0; end
      end
      1: begin
        if (c >= 8'h20 && c <= 8'h7E) begin
          v = int'(c) ^ int'(mLfsr[7:0]);
          expQ.push_back(tbHexChar(v / 16));
          expQ.push_back(tbHexChar(v % 16));
          mLfsr = tbStep(mLfsr);
        end
      end
      2: begin
        if (!tbIsHex(c)) modelBad();
        else if (!mHaveHi) begin
          mHi = tbHexVal(c);
          mHaveHi = 1;
        end else begin
          v = (mHi * 16 + tbHexVal(c)) ^ int'(mLfsr[7:0]);
          expQ.push_back((v >= 32 && v <= 126) ? 8'(v) : 8'h2E);
          mLfsr = tbStep(mLfsr);
          mHaveHi = 0;
        end
      end
      default: begin
        if (!tbIsHex(c)) modelBad();
        else if (mNib < 8) begin
          mShadow = mShadow * 16 + 32'(tbHexVal(c));
          mNib++;
          if (mNib == 8) mLfsr = (mShadow == 0) ? 32'd1 : mShadow;
        end
      end
    endcase
  endtask

  task automatic doReset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    tick();
    tick();
    rst = 1'b0;
    mLfsr = 32'd1; mMode = 0; mHaveHi = 0; mHi = 0; mNib = 0; mShadow = 0; mBad = 0;
    tick();
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic driveRx(input logic [7:0] c);
    rx_data = c;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sendChar(input logic [7:0] c);
    int n;
    driveRx(c);
    tick();
    n = 0;
    while (tx_valid && n < 300) begin
      tick();
      n++;
    end
    check("tx_drain_timeout", 32'(n < 300), 32'd1);
    modelChar(c);
    tick();
  endtask

  task automatic sendStr(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) sendChar(8'(s[i]));
    check({tag, "_mode"}, 32'(mode), 32'(mMode));
    check({tag, "_bad_char"}, 32'(bad_char), 32'(mBad));
    check({tag, "_print_cnt"}, 32'(printCnt), 32'(expPrints));
  endtask

  task automatic expectExact(input string tag, input string e);
    check({tag, "_len"}, 32'(gotQ.size()), 32'(e.len()));
    for (int i = 0; i < e.len() && i < gotQ.size(); i++)
      check($sformatf("%s_ch%0d", tag, i), 32'(gotQ[i]), 32'(8'(e[i])));
  endtask

  task automatic compareModel(input string tag);
    check({tag, "_model_len"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      check($sformatf("%s_model_ch%0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    string key;
    string cmd;
    string plain;
    string cipher;
    logic [7:0] snap;
    logic [7:0] c;
    bit stable;
    int n;
    int v;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;

    // Reset state
    doReset();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_print_buf", 32'(print_buf), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_bad_char", 32'(bad_char), 32'd0);

    // Test 1: key 1, encrypt 'A'
    sendStr("L", "t1_L");
    check("t1_mode_load", 32'(mode), 32'd3);
    sendStr("00000001\r", "t1_key");
    sendStr("E", "t1_E");
    check("t1_mode_enc", 32'(mode), 32'd1);
    sendStr("A\r", "t1_enc");
    expectExact("t1", "40");
    compareModel("t1");
    check("t1_prints", 32'(printCnt), 32'd2);

    // Test 2: reload and decrypt the same pair
    sendStr("L00000001\rD40\r", "t2");
    expectExact("t2", "A");
    compareModel("t2");

    // Test 3: back-pressure in ENC_HI, hold a 2nd char, drop a 3rd
    doReset();
    sendStr("L00000001\rE", "t3_setup");
    forceReady = 1'b0;
    tick();
    driveRx("A");
    tick();
    check("t3_valid", 32'(tx_valid), 32'd1);
    check("t3_hi", 32'(tx_data), 32'h34);
    snap = tx_data;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) driveRx("B");
      else if (i == 6) begin
        check("t3_no_overrun_yet", 32'(overrun), 32'd0);
        driveRx("C");
      end else tick();
      if (!(tx_valid === 1'b1 && tx_data === snap)) stable = 0;
    end
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_overrun", 32'(overrun), 32'd1);
    modelChar("A");
    modelChar("B");
    forceReady = 1'b1;
    n = 0;
    while (gotQ.size() < 4 && n < 100) begin tick(); n++; end
    check("t3_release_timeout", 32'(n < 100), 32'd1);
    tick();
    check("t3_idle_after", 32'(tx_valid), 32'd0);
    check("t3_ch0", 32'(gotQ[0]), 32'h34);
    check("t3_ch1", 32'(gotQ[1]), 32'h30);
    compareModel("t3");
    sendStr("\r", "t3_cr");

    // Test 4: partial key leaves the key untouched
    doReset();
    check("t4_overrun_cleared", 32'(overrun), 32'd0);
    sendStr("L12\rEA\r", "t4");
    expectExact("t4", "40");
    compareModel("t4");

    // Test 5: all-zero key loads 1
    doReset();
    sendStr("EAB\r", "t5_pre");
    compareModel("t5_pre");
    sendStr("L00000000\rEA\r", "t5");
    expectExact("t5", "40");
    compareModel("t5");

    // Test 6: bad char in decrypt
    doReset();
    sendStr("DZ", "t6");
`ifdef SC_BADCHAR_FLAG_EN
    expectExact("t6", "?");
    check("t6_bad_char", 32'(bad_char), 32'd1);
`else
    expectExact("t6", "");
    check("t6_bad_char", 32'(bad_char), 32'd0);
`endif
    compareModel("t6");
    sendStr("\rD4\rD", "t6_clear");
    compareModel("t6_clear");
    sendStr("\r", "t6_cr");

    // Randomized round trips under random back-pressure
    doReset();
    randReady = 1'b1;
    for (int r = 0; r < 4; r++) begin
      key = "";
      for (int k = 0; k < 8; k++) begin
        v = int'($urandom_range(0, 15));
        if (v < 10) c = 8'(48 + v);
        else c = $urandom_range(0, 1) ? 8'(87 + v) : 8'(55 + v);
        key = $sformatf("%s%c", key, c);
      end
      sendStr($sformatf("L%s\r", key), "rnd_key");
      cmd = "E";
      plain = "";
      for (int k = 0; k < 6; k++) begin
        c = 8'($urandom_range(1, 127));
        if (c == 8'h0D) c = "Q";
        cmd = $sformatf("%s%c", cmd, c);
        if (c >= 8'h20 && c <= 8'h7E) plain = $sformatf("%s%c", plain, c);
      end
      sendStr($sformatf("%s\r", cmd), "rnd_enc");
      cipher = "";
      foreach (expQ[i]) cipher = $sformatf("%s%c", cipher, expQ[i]);
      compareModel("rnd_enc");
      sendStr($sformatf("L%s\rD%s\r", key, cipher), "rnd_dec");
      expectExact("rnd_round_trip", plain);
      compareModel("rnd_dec");
      cmd = "D";
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 1) ? 8'h7A : 8'h47;
        else begin
          v = int'($urandom_range(0, 15));
          if (v < 10) c = 8'(48 + v);
          else c = $urandom_range(0, 1) ? 8'(87 + v) : 8'(55 + v);
        end
        cmd = $sformatf("%s%c", cmd, c);
      end
      sendStr($sformatf("%s\r", cmd), "rnd_dec_any");
      compareModel("rnd_dec_any");
    end
    randReady = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
